// File: rtl/swerv_types_pkg.sv
// rtl/swerv_types_pkg.sv - shared types for the LSU/DMA DCCM arbiter
package swerv_types_pkg;

    typedef enum logic {
        LSU_PRI = 1'b0,
        DMA_PRI = 1'b1
    } dccm_arb_state_e;

    localparam int STARVE_MAX_DEFAULT = 7;
    localparam int STARVE_CNT_W       = 3;

endpackage

// File: rtl/lsu_dccm_rsp_buf.sv
// rtl/lsu_dccm_rsp_buf.sv - one-entry DMA read response buffer with DCCM data bypass
module lsu_dccm_rsp_buf #(
    parameter int DATA_W = 39
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              freeze,
    input  logic              rd_grant,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rsp_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata
);

    logic              pending;
    logic              buf_valid;
    logic [DATA_W-1:0] buf_data;
    logic              bypass;

    // Array data is presented straight through in the first unfrozen cycle
    // after the grant and only registered if the consumer is not ready.
    assign bypass    = pending & ~freeze & ~buf_valid;
    assign rsp_valid = buf_valid | bypass;
    assign rsp_rdata = bypass ? rd_data : buf_data;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            pending   <= 1'b0;
            buf_valid <= 1'b0;
            buf_data  <= '0;
        end else begin
            pending <= rd_grant | (pending & freeze);
            if (bypass) begin
                buf_data  <= rd_data;
                buf_valid <= ~rsp_ready;
            end else if (buf_valid && rsp_ready) begin
                buf_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/lsu_dccm_arb.sv
// rtl/lsu_dccm_arb.sv - LSU/DMA arbiter for the single DCCM port with DMA starvation guard
module lsu_dccm_arb
    import swerv_types_pkg::*;
#(
    parameter int DCCM_BITS  = 16,
    parameter int DATA_W     = 39,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic                 lsu_freeze_dc3,
    input  logic                 lsu_rden,
    input  logic                 lsu_wren,
    input  logic [DCCM_BITS-1:0] lsu_rd_addr_lo,
    input  logic [DCCM_BITS-1:0] lsu_rd_addr_hi,
    input  logic [DCCM_BITS-1:0] lsu_wr_addr,
    input  logic [DATA_W-1:0]    lsu_wr_data,
    output logic                 lsu_stall,
    input  logic                 dma_req_valid,
    input  logic                 dma_req_write,
    input  logic [DCCM_BITS-1:0] dma_req_addr,
    input  logic [DATA_W-1:0]    dma_req_wdata,
    output logic                 dma_req_ready,
    output logic                 dma_rsp_valid,
    input  logic                 dma_rsp_ready,
    output logic [DATA_W-1:0]    dma_rsp_rdata,
    output logic                 dccm_rden,
    output logic                 dccm_wren,
    output logic [DCCM_BITS-1:0] dccm_rd_addr_lo,
    output logic [DCCM_BITS-1:0] dccm_rd_addr_hi,
    output logic [DCCM_BITS-1:0] dccm_wr_addr,
    output logic [DATA_W-1:0]    dccm_wr_data,
    input  logic [DATA_W-1:0]    dccm_rd_data_lo
);

    localparam logic [STARVE_CNT_W-1:0] CNT_SAT    = '1;
    localparam logic [STARVE_CNT_W-1:0] STARVE_LIM =
        (STARVE_MAX > 7) ? CNT_SAT : STARVE_CNT_W'(STARVE_MAX);

    dccm_arb_state_e         state, state_nxt;
    logic [STARVE_CNT_W-1:0] starve_cnt, starve_cnt_nxt;
    logic                    lsu_req;
    logic                    dma_can_issue;
    logic                    lsu_grant;
    logic                    dma_grant;

    assign lsu_req = lsu_rden | lsu_wren;

    // A read may only issue if its data has somewhere to land next cycle.
    assign dma_can_issue = dma_req_write | ~dma_rsp_valid | dma_rsp_ready;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state      <= LSU_PRI;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        starve_cnt_nxt = starve_cnt;
        lsu_grant      = 1'b0;
        dma_grant      = 1'b0;
        if (!lsu_freeze_dc3) begin
            case (state)
                LSU_PRI: begin
                    lsu_grant = lsu_req;
                    dma_grant = ~lsu_req & dma_req_valid & dma_can_issue;
                end
                DMA_PRI: begin
                    dma_grant = dma_req_valid & dma_can_issue;
                    lsu_grant = lsu_req & ~dma_grant;
                end
                default: ;
            endcase

            if (!dma_req_valid || dma_grant) begin
                starve_cnt_nxt = '0;
            end else if (starve_cnt != CNT_SAT) begin
                starve_cnt_nxt = starve_cnt + 1'b1;
            end

            if (state == DMA_PRI) begin
                if (dma_grant || !dma_req_valid) begin
                    state_nxt = LSU_PRI;
                end
            end else if (dma_req_valid && !dma_grant && starve_cnt_nxt >= STARVE_LIM) begin
                state_nxt = DMA_PRI;
            end
        end
    end

    always_comb begin
        dccm_rden       = 1'b0;
        dccm_wren       = 1'b0;
        dccm_rd_addr_lo = lsu_rd_addr_lo;
        dccm_rd_addr_hi = lsu_rd_addr_hi;
        dccm_wr_addr    = lsu_wr_addr;
        dccm_wr_data    = lsu_wr_data;
        if (lsu_grant) begin
            dccm_wren = lsu_wren;
            dccm_rden = lsu_rden & ~lsu_wren;
        end else if (dma_grant) begin
            dccm_wren = dma_req_write;
            dccm_rden = ~dma_req_write;
            if (dma_req_write) begin
                dccm_wr_addr = dma_req_addr;
                dccm_wr_data = dma_req_wdata;
            end else begin
                dccm_rd_addr_lo = dma_req_addr;
                dccm_rd_addr_hi = dma_req_addr;
            end
        end
    end

    assign lsu_stall     = ~lsu_freeze_dc3 & lsu_req & ~lsu_grant;
    assign dma_req_ready = dma_grant;

    lsu_dccm_rsp_buf #(
        .DATA_W(DATA_W)
    ) u_rsp_buf (
        .clk       (clk),
        .rst_l     (rst_l),
        .freeze    (lsu_freeze_dc3),
        .rd_grant  (dma_grant & ~dma_req_write),
        .rd_data   (dccm_rd_data_lo),
        .rsp_ready (dma_rsp_ready),
        .rsp_valid (dma_rsp_valid),
        .rsp_rdata (dma_rsp_rdata)
    );

endmodule

// File: tb/tb_lsu_dccm_arb.sv
// tb/tb_lsu_dccm_arb.sv - self-checking bench for lsu_dccm_arb
module tb_lsu_dccm_arb;

    localparam int AW = 16;
    localparam int DW = 39;

    logic          clk = 1'b0;
    logic          rst_l;
    logic          lsu_freeze_dc3;
    logic          lsu_rden, lsu_wren;
    logic [AW-1:0] lsu_rd_addr_lo, lsu_rd_addr_hi, lsu_wr_addr;
    logic [DW-1:0] lsu_wr_data;
    logic          lsu_stall;
    logic          dma_req_valid, dma_req_write;
    logic [AW-1:0] dma_req_addr;
    logic [DW-1:0] dma_req_wdata;
    logic          dma_req_ready;
    logic          dma_rsp_valid, dma_rsp_ready;
    logic [DW-1:0] dma_rsp_rdata;
    logic          dccm_rden, dccm_wren;
    logic [AW-1:0] dccm_rd_addr_lo, dccm_rd_addr_hi, dccm_wr_addr;
    logic [DW-1:0] dccm_wr_data;
    logic [DW-1:0] dccm_rd_data_lo;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lsu_dccm_arb #(.DCCM_BITS(AW), .DATA_W(DW), .STARVE_MAX(7)) dut (
        .clk             (clk),
        .rst_l           (rst_l),
        .lsu_freeze_dc3  (lsu_freeze_dc3),
        .lsu_rden        (lsu_rden),
        .lsu_wren        (lsu_wren),
        .lsu_rd_addr_lo  (lsu_rd_addr_lo),
        .lsu_rd_addr_hi  (lsu_rd_addr_hi),
        .lsu_wr_addr     (lsu_wr_addr),
        .lsu_wr_data     (lsu_wr_data),
        .lsu_stall       (lsu_stall),
        .dma_req_valid   (dma_req_valid),
        .dma_req_write   (dma_req_write),
        .dma_req_addr    (dma_req_addr),
        .dma_req_wdata   (dma_req_wdata),
        .dma_req_ready   (dma_req_ready),
        .dma_rsp_valid   (dma_rsp_valid),
        .dma_rsp_ready   (dma_rsp_ready),
        .dma_rsp_rdata   (dma_rsp_rdata),
        .dccm_rden       (dccm_rden),
        .dccm_wren       (dccm_wren),
        .dccm_rd_addr_lo (dccm_rd_addr_lo),
        .dccm_rd_addr_hi (dccm_rd_addr_hi),
        .dccm_wr_addr    (dccm_wr_addr),
        .dccm_wr_data    (dccm_wr_data),
        .dccm_rd_data_lo (dccm_rd_data_lo)
    );

    function automatic logic [DW-1:0] rand_data();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    task automatic idle_inputs();
        lsu_freeze_dc3  = 1'b0;
        lsu_rden        = 1'b0;
        lsu_wren        = 1'b0;
        lsu_rd_addr_lo  = '0;
        lsu_rd_addr_hi  = '0;
        lsu_wr_addr     = '0;
        lsu_wr_data     = '0;
        dma_req_valid   = 1'b0;
        dma_req_write   = 1'b0;
        dma_req_addr    = '0;
        dma_req_wdata   = '0;
        dma_rsp_ready   = 1'b0;
        dccm_rd_data_lo = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_l = 1'b0;
        idle_inputs();
        #3;
        checks++; if ({dccm_rden, dccm_wren, lsu_stall, dma_req_ready, dma_rsp_valid} !== 5'b0) begin failures++; $display("FAIL reset_ctrl got=%b exp=00000", {dccm_rden, dccm_wren, lsu_stall, dma_req_ready, dma_rsp_valid}); end
        checks++; if (dma_rsp_rdata !== '0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", dma_rsp_rdata); end
        checks++; if ({dccm_rd_addr_lo, dccm_rd_addr_hi, dccm_wr_addr, dccm_wr_data} !== '0) begin failures++; $display("FAIL reset_dccm_bus got=%h exp=0", {dccm_rd_addr_lo, dccm_rd_addr_hi, dccm_wr_addr, dccm_wr_data}); end
        @(negedge clk);
        rst_l = 1'b1;
        next_cycle();
    endtask

    task automatic test_lsu_read();
        lsu_rden       = 1'b1;
        lsu_rd_addr_lo = 16'h0100;
        lsu_rd_addr_hi = 16'h0104;
        @(negedge clk);
        checks++; if ({dccm_rden, dccm_wren, lsu_stall, dma_req_ready} !== 4'b1000) begin failures++; $display("FAIL lsu_read_ctrl got=%b exp=1000", {dccm_rden, dccm_wren, lsu_stall, dma_req_ready}); end
        checks++; if (dccm_rd_addr_lo !== 16'h0100) begin failures++; $display("FAIL lsu_read_addr got=%h exp=0100", dccm_rd_addr_lo); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_dma_read();
        logic [DW-1:0] d;
        dma_req_valid = 1'b1;
        dma_req_addr  = 16'h0200;
        dma_rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if ({dma_req_ready, dccm_rden, dma_rsp_valid} !== 3'b110) begin failures++; $display("FAIL dma_read_grant got=%b exp=110", {dma_req_ready, dccm_rden, dma_rsp_valid}); end
        checks++; if ({dccm_rd_addr_lo, dccm_rd_addr_hi} !== {16'h0200, 16'h0200}) begin failures++; $display("FAIL dma_read_addr got=%h exp=02000200", {dccm_rd_addr_lo, dccm_rd_addr_hi}); end
        next_cycle();
        dma_req_valid   = 1'b0;
        d               = rand_data();
        dccm_rd_data_lo = d;
        @(negedge clk);
        checks++; if (dma_rsp_valid !== 1'b1) begin failures++; $display("FAIL dma_read_rsp_valid got=%b exp=1", dma_rsp_valid); end
        checks++; if (dma_rsp_rdata !== d) begin failures++; $display("FAIL dma_read_rsp_data got=%h exp=%h", dma_rsp_rdata, d); end
        next_cycle();
        @(negedge clk);
        checks++; if (dma_rsp_valid !== 1'b0) begin failures++; $display("FAIL dma_read_rsp_drop got=%b exp=0", dma_rsp_valid); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_starve();
        logic [DW-1:0] w;
        w              = rand_data();
        lsu_rden       = 1'b1;
        lsu_rd_addr_lo = 16'h0300;
        dma_req_valid  = 1'b1;
        dma_req_write  = 1'b1;
        dma_req_addr   = 16'h0400;
        dma_req_wdata  = w;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            checks++; if ({dma_req_ready, lsu_stall, dccm_rden, dccm_wren} !== 4'b0010) begin failures++; $display("FAIL starve_wait%0d got=%b exp=0010", i, {dma_req_ready, lsu_stall, dccm_rden, dccm_wren}); end
            next_cycle();
        end
        @(negedge clk);
        checks++; if ({dma_req_ready, lsu_stall, dccm_rden, dccm_wren} !== 4'b1101) begin failures++; $display("FAIL starve_grant got=%b exp=1101", {dma_req_ready, lsu_stall, dccm_rden, dccm_wren}); end
        checks++; if ({dccm_wr_addr, dccm_wr_data} !== {16'h0400, w}) begin failures++; $display("FAIL starve_wr_bus got=%h exp=%h", {dccm_wr_addr, dccm_wr_data}, {16'h0400, w}); end
        next_cycle();
        dma_req_valid = 1'b0;
        @(negedge clk);
        checks++; if ({lsu_stall, dccm_rden} !== 2'b01) begin failures++; $display("FAIL starve_lsu_resume got=%b exp=01", {lsu_stall, dccm_rden}); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d1, d2;
        d1            = rand_data();
        d2            = rand_data();
        dma_rsp_ready = 1'b0;
        dma_req_valid = 1'b1;
        dma_req_addr  = 16'h0500;
        @(negedge clk);
        checks++; if (dma_req_ready !== 1'b1) begin failures++; $display("FAIL b2b_first_grant got=%b exp=1", dma_req_ready); end
        next_cycle();
        dma_req_addr    = 16'h0504;
        dccm_rd_data_lo = d1;
        @(negedge clk);
        checks++; if ({dma_req_ready, dccm_rden, dma_rsp_valid} !== 3'b001) begin failures++; $display("FAIL b2b_second_blocked got=%b exp=001", {dma_req_ready, dccm_rden, dma_rsp_valid}); end
        checks++; if (dma_rsp_rdata !== d1) begin failures++; $display("FAIL b2b_first_data got=%h exp=%h", dma_rsp_rdata, d1); end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            dccm_rd_data_lo = rand_data();
            @(negedge clk);
            checks++; if ({dma_req_ready, dma_rsp_valid} !== 2'b01 || dma_rsp_rdata !== d1) begin failures++; $display("FAIL b2b_hold%0d got=%b/%h exp=01/%h", i, {dma_req_ready, dma_rsp_valid}, dma_rsp_rdata, d1); end
        end
        next_cycle();
        dma_rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if ({dma_req_ready, dccm_rden, dma_rsp_valid} !== 3'b111 || dma_rsp_rdata !== d1) begin failures++; $display("FAIL b2b_drain_refill got=%b/%h exp=111/%h", {dma_req_ready, dccm_rden, dma_rsp_valid}, dma_rsp_rdata, d1); end
        checks++; if (dccm_rd_addr_lo !== 16'h0504) begin failures++; $display("FAIL b2b_second_addr got=%h exp=0504", dccm_rd_addr_lo); end
        next_cycle();
        dma_req_valid   = 1'b0;
        dccm_rd_data_lo = d2;
        @(negedge clk);
        checks++; if (dma_rsp_valid !== 1'b1 || dma_rsp_rdata !== d2) begin failures++; $display("FAIL b2b_second_data got=%b/%h exp=1/%h", dma_rsp_valid, dma_rsp_rdata, d2); end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++; if (dma_rsp_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%b exp=0", dma_rsp_valid); end
        next_cycle();
    endtask

    task automatic test_freeze();
        logic [DW-1:0] d;
        d             = rand_data();
        dma_req_valid = 1'b1;
        dma_req_addr  = 16'h0600;
        dma_rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (dma_req_ready !== 1'b1) begin failures++; $display("FAIL freeze_grant got=%b exp=1", dma_req_ready); end
        next_cycle();
        lsu_freeze_dc3  = 1'b1;
        lsu_rden        = 1'b1;
        dma_req_write   = 1'b1;
        dccm_rd_data_lo = d;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if ({dccm_rden, dccm_wren, dma_req_ready, lsu_stall, dma_rsp_valid} !== 5'b0) begin failures++; $display("FAIL freeze_quiet%0d got=%b exp=00000", i, {dccm_rden, dccm_wren, dma_req_ready, lsu_stall, dma_rsp_valid}); end
            next_cycle();
        end
        lsu_freeze_dc3 = 1'b0;
        lsu_rden       = 1'b0;
        dma_req_valid  = 1'b0;
        @(negedge clk);
        checks++; if (dma_rsp_valid !== 1'b1 || dma_rsp_rdata !== d) begin failures++; $display("FAIL freeze_rsp got=%b/%h exp=1/%h", dma_rsp_valid, dma_rsp_rdata, d); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_reset_mid_read();
        dma_req_valid = 1'b1;
        dma_req_addr  = 16'h0700;
        @(negedge clk);
        checks++; if (dma_req_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_grant got=%b exp=1", dma_req_ready); end
        next_cycle();
        dma_req_valid   = 1'b0;
        dccm_rd_data_lo = rand_data();
        #1;
        checks++; if (dma_rsp_valid !== 1'b1) begin failures++; $display("FAIL rst_mid_before got=%b exp=1", dma_rsp_valid); end
        rst_l = 1'b0;
        #1;
        checks++; if (dma_rsp_valid !== 1'b0 || dma_rsp_rdata !== '0) begin failures++; $display("FAIL rst_mid_clear got=%b/%h exp=0/0", dma_rsp_valid, dma_rsp_rdata); end
        @(negedge clk);
        rst_l = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            @(negedge clk);
            checks++; if (dma_rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_after%0d got=%b exp=0", i, dma_rsp_valid); end
        end
        next_cycle();
        idle_inputs();
    endtask

    // Reference: DMA gets the port when LSU is idle, or once it has waited
    // seven cycles; each read returns the array data seen in the first
    // unfrozen cycle after its grant and then waits in a one-deep queue.
    task automatic test_random();
        bit            m_dma_pri;
        int            m_wait;
        bit            m_pend;
        logic [DW-1:0] m_q[$];
        bit            frz, lreq, vis, can, lg, dg, e_rd, e_wr, heavy;
        logic [DW-1:0] edata;
        logic [AW-1:0] e_lo, e_hi;
        rst_l = 1'b0;
        idle_inputs();
        #2;
        @(negedge clk);
        rst_l = 1'b1;
        next_cycle();
        m_dma_pri = 1'b0;
        m_wait    = 0;
        m_pend    = 1'b0;
        m_q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            heavy           = ((cyc / 250) % 2) == 1;
            lsu_freeze_dc3  = ($urandom_range(0, 11) == 0);
            lsu_rden        = heavy ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0);
            lsu_wren        = ($urandom_range(0, 5) == 0);
            lsu_rd_addr_lo  = AW'($urandom());
            lsu_rd_addr_hi  = AW'($urandom());
            lsu_wr_addr     = AW'($urandom());
            lsu_wr_data     = rand_data();
            dma_req_valid   = heavy ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 1) == 1);
            dma_req_write   = ($urandom_range(0, 1) == 1);
            dma_req_addr    = AW'($urandom());
            dma_req_wdata   = rand_data();
            dma_rsp_ready   = ($urandom_range(0, 2) != 0);
            dccm_rd_data_lo = rand_data();
            @(negedge clk);
            frz   = lsu_freeze_dc3;
            lreq  = lsu_rden || lsu_wren;
            vis   = (m_q.size() > 0) || (m_pend && !frz);
            edata = (m_q.size() > 0) ? m_q[0] : dccm_rd_data_lo;
            can   = dma_req_write || !vis || dma_rsp_ready;
            lg    = 1'b0;
            dg    = 1'b0;
            if (!frz) begin
                if (m_dma_pri) begin
                    dg = dma_req_valid && can;
                    lg = lreq && !dg;
                end else begin
                    lg = lreq;
                    dg = !lreq && dma_req_valid && can;
                end
            end
            e_rd = lg ? (lsu_rden && !lsu_wren) : (dg && !dma_req_write);
            e_wr = lg ? lsu_wren : (dg && dma_req_write);
            e_lo = lg ? lsu_rd_addr_lo : dma_req_addr;
            e_hi = lg ? lsu_rd_addr_hi : dma_req_addr;
            checks++; if ({dccm_rden, dccm_wren, lsu_stall, dma_req_ready, dma_rsp_valid} !== {e_rd, e_wr, !frz && lreq && !lg, dg, vis}) begin failures++; $display("FAIL rand_ctrl cyc=%0d got=%b exp=%b", cyc, {dccm_rden, dccm_wren, lsu_stall, dma_req_ready, dma_rsp_valid}, {e_rd, e_wr, !frz && lreq && !lg, dg, vis}); end
            if (vis) begin
                checks++; if (dma_rsp_rdata !== edata) begin failures++; $display("FAIL rand_rsp_data cyc=%0d got=%h exp=%h", cyc, dma_rsp_rdata, edata); end
            end
            if (e_rd) begin
                checks++; if ({dccm_rd_addr_lo, dccm_rd_addr_hi} !== {e_lo, e_hi}) begin failures++; $display("FAIL rand_rd_addr cyc=%0d got=%h exp=%h", cyc, {dccm_rd_addr_lo, dccm_rd_addr_hi}, {e_lo, e_hi}); end
            end
            if (e_wr) begin
                checks++; if ({dccm_wr_addr, dccm_wr_data} !== (lg ? {lsu_wr_addr, lsu_wr_data} : {dma_req_addr, dma_req_wdata})) begin failures++; $display("FAIL rand_wr_bus cyc=%0d got=%h lsu=%0b", cyc, {dccm_wr_addr, dccm_wr_data}, lg); end
            end
            if (vis && dma_rsp_ready) begin
                if (m_q.size() > 0) void'(m_q.pop_front());
            end else if (vis && m_q.size() == 0) begin
                m_q.push_back(dccm_rd_data_lo);
            end
            if (m_pend && !frz) m_pend = 1'b0;
            if (dg && !dma_req_write) m_pend = 1'b1;
            if (!frz) begin
                if (!dma_req_valid || dg) m_wait = 0;
                else if (m_wait < 7) m_wait++;
                if (m_dma_pri) begin
                    if (dg || !dma_req_valid) m_dma_pri = 1'b0;
                end else if (dma_req_valid && !dg && m_wait >= 7) begin
                    m_dma_pri = 1'b1;
                end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_lsu_read();
        test_dma_read();
        test_starve();
        test_back_to_back();
        test_freeze();
        test_reset_mid_read();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout reached before summary");
        $fatal(1);
    end

endmodule

// File: doc/lsu_dccm_arb.md
LSU_DCCM_ARB -- requirements
Module: lsu_dccm_arb

Interface
REQ-001 SHALL have parameters: DCCM_BITS, default 16, DCCM byte-address width; DATA_W, default 39, data+ECC width; STARVE_MAX, default 7, DMA wait-cycle limit.
REQ-002 SHALL have ports, one per line:
clk  in  1  sole clock
rst_l  in  1  reset, asynchronous, active-low
lsu_freeze_dc3  in  1  pipe freeze
lsu_rden / lsu_wren  in  1 each  LSU read / write request
lsu_rd_addr_lo / lsu_rd_addr_hi / lsu_wr_addr  in  DCCM_BITS each  LSU addresses
lsu_wr_data  in  DATA_W  LSU write data
lsu_stall  out  1  LSU request not granted this cycle
dma_req_valid / dma_req_write  in  1 each  DMA request, 1=write
dma_req_addr  in  DCCM_BITS  DMA address
dma_req_wdata  in  DATA_W  DMA write data
dma_req_ready  out  1  DMA request accepted
dma_rsp_valid  out  1  DMA read data valid
dma_rsp_ready  in  1  DMA response consumed
dma_rsp_rdata  out  DATA_W  DMA read data
dccm_rden / dccm_wren  out  1 each  to DCCM array
dccm_rd_addr_lo / dccm_rd_addr_hi / dccm_wr_addr  out  DCCM_BITS each  to DCCM
dccm_wr_data  out  DATA_W  to DCCM
dccm_rd_data_lo  in  DATA_W  DCCM read data, valid 1 cycle after dccm_rden

Function
REQ-003 SHALL issue at most one DCCM access per cycle; dccm_rden and dccm_wren never both 1.
REQ-004 SHALL issue nothing while lsu_freeze_dc3=1: dccm_rden=dccm_wren=0, dma_req_ready=0, lsu_stall=0; starve counter holds.
REQ-005 SHALL use FSM states LSU_PRI (reset) and DMA_PRI.
REQ-006 In LSU_PRI, an LSU request wins; lsu_stall=0, DCCM outputs driven from LSU inputs combinationally, LSU write has priority over LSU read.
REQ-007 In LSU_PRI with no LSU request, a DMA request is granted if dma_can_issue; dma_req_ready=1 same cycle.
REQ-008 dma_can_issue SHALL be 1 when dma_req_write=1, or the response buffer is empty, or it is draining this cycle (dma_rsp_valid & dma_rsp_ready).
REQ-009 A DMA read SHALL drive dccm_rd_addr_lo = dccm_rd_addr_hi = dma_req_addr; a DMA write drives dccm_wr_addr, dccm_wr_data.
REQ-010 3-bit saturating starve counter SHALL increment each non-frozen cycle dma_req_valid=1 and DMA not granted; clear on DMA grant or dma_req_valid=0.
REQ-011 Counter reaching STARVE_MAX with dma_req_valid=1 SHALL move FSM to DMA_PRI next cycle.
REQ-012 In DMA_PRI, DMA SHALL be granted if dma_can_issue, with lsu_stall=1 if an LSU request is present; FSM returns to LSU_PRI after a DMA grant or if dma_req_valid drops.
REQ-013 In DMA_PRI with dma_can_issue=0, LSU SHALL be served normally and FSM stays in DMA_PRI.
REQ-014 A granted DMA read SHALL set a 1-bit pending flag; next non-frozen cycle dccm_rd_data_lo is captured into a one-entry response buffer, dma_rsp_valid=1.
REQ-015 dma_rsp_valid/dma_rsp_rdata SHALL hold stable until dma_rsp_ready=1; same-cycle drain and refill keeps dma_rsp_valid=1 with new data next cycle.
REQ-016 Freeze arriving while the pending flag is set SHALL delay capture until freeze clears; DCCM output holds data meanwhile.
REQ-017 DMA write SHALL complete on grant; no response generated.

Reset
REQ-018 On rst_l=0, asynchronously: FSM=LSU_PRI, counter=0, pending=0, dma_rsp_valid=0, dma_rsp_rdata=0; combinational outputs follow inputs, so with no requests all outputs are 0.
REQ-019 Reset mid-read SHALL drop the pending response; no dma_rsp_valid after release.

Structure
REQ-020 SHALL place state enum (LSU_PRI, DMA_PRI) and STARVE_MAX default in swerv_types_pkg.
REQ-021 SHALL instantiate one sub-module, lsu_dccm_rsp_buf, for the response buffer; flops use existing rvdff family.

Verification
REQ-022 LSU read 0x0100 with DMA idle -> dccm_rden=1, addr 0x0100, lsu_stall=0, dma_req_ready=0.
REQ-023 DMA read 0x0200 alone, dma_rsp_ready=1 -> dma_req_ready=1 cycle N, dma_rsp_valid=1 cycle N+1 with DCCM data.
REQ-024 Continuous LSU reads, DMA write pending -> 7 DMA stall cycles, DMA_PRI, 8th-cycle grant with lsu_stall=1, LSU resumes next cycle.
REQ-025 DMA reads back-to-back with dma_rsp_ready=0 -> second read not granted, response data stable until ready.
REQ-026 Freeze asserted cycle after DMA read grant for 3 cycles -> no DCCM enables, dma_rsp_valid rises first unfrozen cycle with correct data.
REQ-027 rst_l low during pending read -> all registered outputs 0 immediately, no response after release.
